mprj_checkpoint_monitor: RTL
============================

# mprj_checkpoint_monitor

Cycle-accurate monitor for the firmware checkpoint bus driven on `mprj_io[31:16]`, replacing ad-hoc `wait(checkbits == ...)` chains in the top-level benches. It debounces the bus, tracks an ordered sequence of N tests, checks that start and end markers arrive in order, measures each test's run length in clock cycles, and flags a timeout or protocol fault. It is synthesizable, so it can sit inside the bench next to `caravel` or inside the user project as an on-chip self-check.

## Interface
- `W`, 16: checkpoint bus width; must be at least 16.
- `PREFIX`, 8'hAB: marker prefix, compared against `checkbits[15:8]`.
- `FIRST_ID`, 1: ID of the first test.
- `N_TESTS`, 2: number of tests expected, 1..15; `FIRST_ID + N_TESTS - 1` must be at most 15.
- `STABLE`, 4: number of consecutive identical samples before a value is accepted, at least 1.
- `TIMEOUT`, 100000: maximum cycles allowed per test, counted from the accepted start marker.
- `CNT_W`, 20: width of the cycle counter; must satisfy `2^CNT_W > TIMEOUT`.

Ports:
- `clock` in 1: single clock.
- `resetb` in 1: reset, asynchronous, active-low.
- `enable` in 1: when low, sampling and counting are frozen and the FSM holds its state.
- `checkbits` in W: checkpoint bus.
- `cur_id` out 4: ID of the test currently expected or running.
- `active` out 1: high while in RUN.
- `done_pulse` out 1: one-cycle pulse when a valid end marker is accepted.
- `last_cycles` out CNT_W: run length of the most recently completed test.
- `all_pass` out 1: sticky; set once all N tests have completed.
- `fail` out 1: sticky; set on any fault.
- `fail_code` out 2: 0 = none, 1 = out-of-order marker, 2 = timeout, 3 = end marker without a preceding start.

## Operation
- **Debounce.** A shadow register and a stability counter track the bus. When `checkbits` differs from the shadow, the shadow reloads and the counter clears. After the value has been seen `STABLE` consecutive cycles it becomes `acc`, and exactly one `acc_valid` pulse is generated per distinct accepted value; a value that stays put never re-triggers.
- **Decode.** An accepted value is a marker only if `acc[15:8] == PREFIX`. The marker ID is `acc[7:4]` and the phase is `acc[3:0]`: 0 means start, 1 means end. Any other phase, or any non-prefix value, is ignored.
- **FSM states:** IDLE, RUN, PASS, FAIL.
  - IDLE, start marker with ID == `cur_id` → RUN. The counter clears to 0.
  - IDLE, start marker with any other ID → FAIL, code 1.
  - IDLE, end marker → FAIL, code 3.
  - RUN, end marker with ID == `cur_id` → load `last_cycles` from the counter and pulse `done_pulse`. If `cur_id == FIRST_ID + N_TESTS - 1`, go to PASS; otherwise increment `cur_id` and go to IDLE.
  - RUN, any other marker → FAIL, code 1.
  - RUN, counter reaches `TIMEOUT` → FAIL, code 2. The counter saturates at `TIMEOUT`.
  - PASS and FAIL are terminal until reset. Markers arriving in these states are ignored.
- **Simultaneous events.** If the timeout and a valid end marker occur in the same cycle, the end marker wins.
- **Cycle counting.** The counter increments by one per cycle in RUN while `enable` is high. `last_cycles` equals the number of cycles from the cycle after start acceptance through the cycle of end acceptance.
- **Reset mid-operation.** Reset returns everything to reset values immediately and asynchronously.

## Timing
- Reset values: `cur_id = FIRST_ID`; `active`, `done_pulse`, `last_cycles`, `all_pass`, `fail` and `fail_code` all 0; the shadow register and `acc` take the value `{W{1'b0}}`.
- Marker latency: `acc_valid` asserts `STABLE` cycles after the bus changes. The FSM transition and outputs update 1 cycle after that, for a total of `STABLE + 1` cycles from bus edge to `active` or `done_pulse`.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `ckpt_pkg` holds:
  - the FSM state enum;
  - the `fail_code` localparams (`FC_NONE`, `FC_ORDER`, `FC_TIMEOUT`, `FC_ORPHAN_END`);
  - the phase constants `PH_START = 4'h0` and `PH_END = 4'h1`.
- Sub-module `ckpt_debounce` (parameters `W`, `STABLE`) produces `acc` and `acc_valid`. The FSM and the counter live in the top module.

## Test plan
1. Default parameters with `STABLE = 4`: drive AB10, hold 500 cycles, drive AB11, then AB20, hold 300 cycles, AB21 → two `done_pulse`s, `last_cycles` = 500 then 300, `all_pass = 1`, `fail = 0`.
2. Glitch: drive AB10 for 2 cycles, then 0000 → no transition. `active` stays 0 and `cur_id` stays 1.
3. Out of order: AB20 while in IDLE with `cur_id = 1` → `fail = 1`, `fail_code = 1` at `STABLE + 1` cycles after the bus edge.
4. Timeout with `TIMEOUT = 50`: AB10 and then hold → `fail_code = 2` exactly 50 cycles after RUN entry. A subsequent AB11 is ignored.
5. Orphan end: AB11 in IDLE → `fail_code = 3`. Then AB10 while `enable = 0` for 100 cycles → counter frozen.
6. Reset mid-RUN: assert `resetb = 0` during test 2 → all outputs return to their reset values asynchronously, `cur_id = 1`, and a fresh AB10/AB11 sequence is accepted afterwards.

Source files
------------

// File: rtl/ckpt_pkg.sv
// Shared types and constants for the firmware checkpoint monitor.
package ckpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_ORDER      = 2'd1;
  localparam logic [1:0] FC_TIMEOUT    = 2'd2;
  localparam logic [1:0] FC_ORPHAN_END = 2'd3;

  localparam logic [3:0] PH_START = 4'h0;
  localparam logic [3:0] PH_END   = 4'h1;

  // Layout of the low 16 bits of an accepted checkpoint value.
  typedef struct packed {
    logic [7:0] prefix;
    logic [3:0] id;
    logic [3:0] phase;
  } marker_t;

endpackage

// File: rtl/ckpt_debounce.sv
// Debounces the checkpoint bus: a value must hold for STABLE samples before
// it is accepted, and each newly accepted value pulses acc_valid once.
module ckpt_debounce
  import ckpt_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned STABLE = 4
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic         enable,
  input  logic [W-1:0] checkbits,
  output logic [W-1:0] acc,
  output logic         acc_valid
);

  localparam int unsigned SW = $clog2(STABLE + 1);

  logic [W-1:0]  shadow;
  logic [SW-1:0] seen;
  logic [SW-1:0] seen_nxt;
  logic          take;

  // seen counts samples of the shadow value, including the reloading sample,
  // and saturates at STABLE so a held value cannot re-trigger.
  always_comb begin
    seen_nxt = seen;
    take     = 1'b0;
    if (checkbits != shadow) begin
      seen_nxt = SW'(1);
    end else if (seen != SW'(STABLE)) begin
      seen_nxt = seen + SW'(1);
    end
    if ((seen_nxt == SW'(STABLE)) &&
        !((checkbits == shadow) && (seen == SW'(STABLE))) &&
        (checkbits != acc)) begin
      take = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      shadow    <= '0;
      seen      <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
    end else if (enable) begin
      shadow    <= checkbits;
      seen      <= seen_nxt;
      acc_valid <= take;
      if (take) begin
        acc <= checkbits;
      end
    end
  end

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Tracks an ordered sequence of firmware tests on the checkpoint bus,
// measuring each test's run length and flagging order faults and timeouts.
module mprj_checkpoint_monitor
  import ckpt_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter logic [7:0]  PREFIX   = 8'hAB,
  parameter int unsigned FIRST_ID = 1,
  parameter int unsigned N_TESTS  = 2,
  parameter int unsigned STABLE   = 4,
  parameter int unsigned TIMEOUT  = 100000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic [W-1:0]     checkbits,
  output logic [3:0]       cur_id,
  output logic             active,
  output logic             done_pulse,
  output logic [CNT_W-1:0] last_cycles,
  output logic             all_pass,
  output logic             fail,
  output logic [1:0]       fail_code
);

  localparam logic [3:0]       LAST_ID = 4'(FIRST_ID + N_TESTS - 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  logic [W-1:0] acc;
  logic         acc_valid;

  ckpt_debounce #(
    .W      (W),
    .STABLE (STABLE)
  ) u_debounce (
    .clock     (clock),
    .resetb    (resetb),
    .enable    (enable),
    .checkbits (checkbits),
    .acc       (acc),
    .acc_valid (acc_valid)
  );

  marker_t mk;
  logic    is_mkr;
  logic    is_start;
  logic    is_end;
  logic    id_ok;

  assign mk       = marker_t'(acc[15:0]);
  assign is_mkr   = acc_valid && (mk.prefix == PREFIX);
  assign is_start = is_mkr && (mk.phase == PH_START);
  assign is_end   = is_mkr && (mk.phase == PH_END);
  assign id_ok    = (mk.id == cur_id);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       cur_id_nxt;
  logic [CNT_W-1:0] last_nxt;
  logic             done_nxt;
  logic             all_pass_nxt;
  logic             fail_nxt;
  logic [1:0]       fc_nxt;
  logic             active_nxt;

  // cnt_inc is the run length including the current cycle, saturated at TIMEOUT.
  assign cnt_inc = (cnt >= TMO) ? TMO : cnt + CNT_W'(1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_id_nxt   = cur_id;
    last_nxt     = last_cycles;
    done_nxt     = 1'b0;
    all_pass_nxt = all_pass;
    fail_nxt     = fail;
    fc_nxt       = fail_code;
    if (enable) begin
      case (state)
        ST_IDLE: begin
          if (is_start && id_ok) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else if (is_start) begin
            state_nxt = ST_FAIL;
            fail_nxt  = 1'b1;
            fc_nxt    = FC_ORDER;
          end else if (is_end) begin
            state_nxt = ST_FAIL;
            fail_nxt  = 1'b1;
            fc_nxt    = FC_ORPHAN_END;
          end
        end
        ST_RUN: begin
          cnt_nxt = cnt_inc;
          // A valid end marker takes priority over a coincident timeout.
          if (is_end && id_ok) begin
            last_nxt = cnt_inc;
            done_nxt = 1'b1;
            if (cur_id == LAST_ID) begin
              state_nxt    = ST_PASS;
              all_pass_nxt = 1'b1;
            end else begin
              state_nxt  = ST_IDLE;
              cur_id_nxt = cur_id + 4'd1;
            end
          end else if (is_start || is_end) begin
            state_nxt = ST_FAIL;
            fail_nxt  = 1'b1;
            fc_nxt    = FC_ORDER;
          end else if (cnt_inc >= TMO) begin
            state_nxt = ST_FAIL;
            fail_nxt  = 1'b1;
            fc_nxt    = FC_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
    active_nxt = (state_nxt == ST_RUN);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur_id      <= 4'(FIRST_ID);
      active      <= 1'b0;
      done_pulse  <= 1'b0;
      last_cycles <= '0;
      all_pass    <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= FC_NONE;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cur_id      <= cur_id_nxt;
      active      <= active_nxt;
      done_pulse  <= done_nxt;
      last_cycles <= last_nxt;
      all_pass    <= all_pass_nxt;
      fail        <= fail_nxt;
      fail_code   <= fc_nxt;
    end
  end

endmodule
